// File: rtl/issue_tracker_mp_pkg.sv
// Shared issue-tracker types: trans-id width helper and per-entry bookkeeping record.
package issue_tracker_mp_pkg;

   localparam int unsigned REG_W = 5;

   function automatic int unsigned trans_id_w(input int unsigned nr_entries);
      return (nr_entries > 1) ? $clog2(nr_entries) : 1;
   endfunction

   typedef struct packed {
      logic             alloc;
      logic             done;
      logic [REG_W-1:0] rd;
   } entry_t;

endpackage

// File: rtl/issue_tracker_mp_if.sv
// Decode/writeback/lookup/commit bundle of the issue tracker; master is the surrounding pipeline.
interface issue_tracker_mp_if
   import issue_tracker_mp_pkg::*;
#(
   parameter int unsigned NR_ENTRIES      = 8,
   parameter int unsigned NR_WB_PORTS     = 4,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NR_RD_PORTS     = 2,
   parameter int unsigned XLEN            = 64
);
   localparam int unsigned IDX_W = trans_id_w(NR_ENTRIES);

   logic                                        flush_i;
   logic                                        issue_valid_i;
   logic                                        issue_ready_o;
   logic [REG_W-1:0]                            issue_rd_i;
   logic [IDX_W-1:0]                            issue_trans_id_o;
   logic [NR_WB_PORTS-1:0]                      wb_valid_i;
   logic [NR_WB_PORTS-1:0][IDX_W-1:0]           wb_trans_id_i;
   logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_data_i;
   logic [NR_RD_PORTS-1:0][REG_W-1:0]           rs_i;
   logic [NR_RD_PORTS-1:0]                      rs_busy_o;
   logic [NR_RD_PORTS-1:0]                      rs_fwd_valid_o;
   logic [NR_RD_PORTS-1:0][XLEN-1:0]            rs_fwd_data_o;
   logic [NR_COMMIT_PORTS-1:0]                  commit_valid_o;
   logic [NR_COMMIT_PORTS-1:0][REG_W-1:0]       commit_rd_o;
   logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]        commit_data_o;
   logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i;
   logic [IDX_W:0]                              count_o;

   modport master (
      output flush_i, issue_valid_i, issue_rd_i, wb_valid_i, wb_trans_id_i, wb_data_i,
             rs_i, commit_ack_i,
      input  issue_ready_o, issue_trans_id_o, rs_busy_o, rs_fwd_valid_o, rs_fwd_data_o,
             commit_valid_o, commit_rd_o, commit_data_o, count_o
   );

   modport slave (
      input  flush_i, issue_valid_i, issue_rd_i, wb_valid_i, wb_trans_id_i, wb_data_i,
             rs_i, commit_ack_i,
      output issue_ready_o, issue_trans_id_o, rs_busy_o, rs_fwd_valid_o, rs_fwd_data_o,
             commit_valid_o, commit_rd_o, commit_data_o, count_o
   );

endinterface

// File: rtl/issue_tracker_fwd_sel.sv
// Youngest-match select: one-hot of the matching entry furthest from head, zero if none.
// Purely combinational.
module issue_tracker_fwd_sel
   import issue_tracker_mp_pkg::*;
#(
   parameter int unsigned NR_ENTRIES = 8
) (
   input  logic [NR_ENTRIES-1:0]             i_match,
   input  logic [trans_id_w(NR_ENTRIES)-1:0] i_head,
   output logic [NR_ENTRIES-1:0]             o_onehot
);
   localparam int unsigned IDX_W = trans_id_w(NR_ENTRIES);

   always_comb begin : sel
      logic [IDX_W-1:0] w_idx;
      w_idx    = '0;
      o_onehot = '0;
      // walk oldest to youngest so the last hit wins
      for (int k = 0; k < NR_ENTRIES; k++) begin
         w_idx = i_head + IDX_W'(k);
         if (i_match[w_idx]) begin
            o_onehot        = '0;
            o_onehot[w_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/issue_tracker_mp.sv
// In-order issue tracker: allocate at tail, out-of-order writeback, in-order multi-commit from head.
// Commit/lookup outputs are 0-cycle from state; issue_ready ignores same-cycle retirement.
module issue_tracker_mp
   import issue_tracker_mp_pkg::*;
#(
   parameter int unsigned NR_ENTRIES      = 8,
   parameter int unsigned NR_WB_PORTS     = 4,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NR_RD_PORTS     = 2,
   parameter int unsigned XLEN            = 64
) (
   input logic                clk_i,
   input logic                rst_ni,
   issue_tracker_mp_if.slave  bus
);
   localparam int unsigned IDX_W = trans_id_w(NR_ENTRIES);
   localparam int unsigned CNT_W = IDX_W + 1;

   entry_t           r_entry [NR_ENTRIES];
   logic [XLEN-1:0]  r_data  [NR_ENTRIES];
   logic [IDX_W-1:0] r_head;
   logic [IDX_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic                       w_fire;
   logic [NR_ENTRIES-1:0]      w_wb_hit;
   logic [XLEN-1:0]            w_wb_dat [NR_ENTRIES];
   logic                       w_dup_wb;
   logic [NR_COMMIT_PORTS-1:0] w_commit_vld;
   logic [NR_ENTRIES-1:0]      w_retire;
   logic [CNT_W-1:0]           w_retire_n;

   assign bus.issue_ready_o    = r_count < CNT_W'(NR_ENTRIES);
   assign bus.issue_trans_id_o = r_tail;
   assign bus.count_o          = r_count;
   assign bus.commit_valid_o   = w_commit_vld;
   assign w_fire               = bus.issue_valid_i & bus.issue_ready_o;

   // per-entry writeback decode; later ports override earlier ones
   always_comb begin : wb_dec
      w_wb_hit = '0;
      w_dup_wb = 1'b0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
         w_wb_dat[i] = '0;
         for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (bus.wb_valid_i[p] && bus.wb_trans_id_i[p] == IDX_W'(i)) begin
               w_dup_wb    = w_dup_wb | w_wb_hit[i];
               w_wb_hit[i] = 1'b1;
               w_wb_dat[i] = bus.wb_data_i[p];
            end
         end
      end
   end

   always_comb begin : commit_sel
      logic [IDX_W-1:0] w_idx;
      logic             w_run;
      w_idx             = '0;
      w_run             = 1'b1;
      w_retire          = '0;
      w_retire_n        = '0;
      w_commit_vld      = '0;
      bus.commit_rd_o   = '0;
      bus.commit_data_o = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         w_idx              = r_head + IDX_W'(k);
         w_commit_vld[k]    = r_entry[w_idx].alloc & r_entry[w_idx].done;
         bus.commit_rd_o[k] = r_entry[w_idx].rd;
         bus.commit_data_o[k] = r_data[w_idx];
         // only an unbroken run of acked, valid slots from head retires
         w_run = w_run & w_commit_vld[k] & bus.commit_ack_i[k];
         if (w_run) begin
            w_retire[w_idx] = 1'b1;
            w_retire_n      = w_retire_n + CNT_W'(1);
         end
      end
   end

   for (genvar r = 0; r < NR_RD_PORTS; r++) begin : g_rd
      logic [NR_ENTRIES-1:0] w_match;
      logic [NR_ENTRIES-1:0] w_sel;
      logic                  w_busy;
      logic                  w_fwd_vld;
      logic [XLEN-1:0]       w_fwd_dat;

      always_comb begin : match
         for (int i = 0; i < NR_ENTRIES; i++)
            w_match[i] = r_entry[i].alloc && (r_entry[i].rd == bus.rs_i[r]);
      end

      issue_tracker_fwd_sel #(.NR_ENTRIES(NR_ENTRIES)) u_fwd_sel (
         .i_match  (w_match),
         .i_head   (r_head),
         .o_onehot (w_sel)
      );

      always_comb begin : lookup
         logic            w_done;
         logic            w_hit;
         logic            w_live;
         logic [XLEN-1:0] w_sdat;
         logic [XLEN-1:0] w_wdat;
         w_done = 1'b0;
         w_hit  = 1'b0;
         w_sdat = '0;
         w_wdat = '0;
         for (int i = 0; i < NR_ENTRIES; i++) begin
            if (w_sel[i]) begin
               w_done = r_entry[i].done;
               w_hit  = w_wb_hit[i];
               w_sdat = r_data[i];
               w_wdat = w_wb_dat[i];
            end
         end
         // x0 never has a producer
         w_live    = (bus.rs_i[r] != '0) && (|w_match);
         w_busy    = w_live & ~w_done & ~w_hit;
         w_fwd_vld = w_live & (w_done | w_hit);
         w_fwd_dat = w_done ? w_sdat : w_wdat;
      end

      assign bus.rs_busy_o[r]      = w_busy;
      assign bus.rs_fwd_valid_o[r] = w_fwd_vld;
      assign bus.rs_fwd_data_o[r]  = w_fwd_dat;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || bus.flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < NR_ENTRIES; i++) r_entry[i] <= '0;
      end else begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            if (w_wb_hit[i] && r_entry[i].alloc) r_entry[i].done <= 1'b1;
            if (w_retire[i])                     r_entry[i]      <= '0;
         end
         // tail slot is never allocated while ready, so it cannot collide with a retire
         if (w_fire) r_entry[r_tail] <= '{alloc: 1'b1, done: 1'b0, rd: bus.issue_rd_i};
         r_head  <= r_head + IDX_W'(w_retire_n);
         r_tail  <= r_tail + IDX_W'(w_fire);
         r_count <= r_count + CNT_W'(w_fire) - w_retire_n;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_ENTRIES; i++)
         if (w_wb_hit[i] && r_entry[i].alloc) r_data[i] <= w_wb_dat[i];
   end

   a_no_dup_wb : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_dup_wb)
      else $warning("two writeback ports target the same entry");

endmodule

// File: tb/tb_issue_tracker_mp.sv
// Directed bench: queue-based reference model checked every cycle plus literal spot checks.
module tb_issue_tracker_mp;
   localparam int NE = 8;
   localparam int NW = 4;
   localparam int NC = 2;
   localparam int NR = 2;
   localparam int XL = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_en = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   issue_tracker_mp_if #(.NR_ENTRIES(NE), .NR_WB_PORTS(NW), .NR_COMMIT_PORTS(NC),
                         .NR_RD_PORTS(NR), .XLEN(XL)) bus ();

   issue_tracker_mp #(.NR_ENTRIES(NE), .NR_WB_PORTS(NW), .NR_COMMIT_PORTS(NC),
                      .NR_RD_PORTS(NR), .XLEN(XL)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [4:0]  rd;
      bit          done;
      logic [63:0] data;
   } ment_t;

   ment_t q[$];
   int    mtail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: ordered queue of in-flight instructions, oldest first
   always @(posedge clk) begin : model_upd
      bit    rdy;
      int    n;
      ment_t e;
      if (!rst_n || bus.flush_i) begin
         q.delete();
         mtail = 0;
      end else begin
         rdy = q.size() < NE;
         n = 0;
         for (int k = 0; k < NC; k++)
            if (k < q.size() && q[k].done && bus.commit_ack_i[k] && n == k) n++;
         for (int p = 0; p < NW; p++)
            if (bus.wb_valid_i[p])
               for (int j = 0; j < q.size(); j++)
                  if (q[j].id == int'(bus.wb_trans_id_i[p])) begin
                     e = q[j]; e.done = 1'b1; e.data = bus.wb_data_i[p]; q[j] = e;
                  end
         repeat (n) void'(q.pop_front());
         if (bus.issue_valid_i && rdy) begin
            e.id = mtail; e.rd = bus.issue_rd_i; e.done = 1'b0; e.data = '0;
            q.push_back(e);
            mtail = (mtail + 1) % NE;
         end
      end
   end

   always @(negedge clk) begin : cmp
      bit          ev, found, hit, eb, efv;
      logic [63:0] efd, wd;
      logic [4:0]  rsv;
      if (chk_en) begin
         check("m_ready", bus.issue_ready_o, q.size() < NE);
         check("m_tid",   bus.issue_trans_id_o, mtail);
         check("m_count", bus.count_o, q.size());
         for (int k = 0; k < NC; k++) begin
            ev = (k < q.size()) && q[k].done;
            check($sformatf("m_cvld%0d", k), bus.commit_valid_o[k], ev);
            if (ev) begin
               check($sformatf("m_crd%0d", k),  bus.commit_rd_o[k],   q[k].rd);
               check($sformatf("m_cdat%0d", k), bus.commit_data_o[k], q[k].data);
            end
         end
         for (int r = 0; r < NR; r++) begin
            rsv = bus.rs_i[r]; eb = 0; efv = 0; efd = '0; found = 0;
            if (rsv != 0)
               for (int j = q.size() - 1; j >= 0; j--)
                  if (!found && q[j].rd == rsv) begin
                     found = 1;
                     if (q[j].done) begin
                        efv = 1; efd = q[j].data;
                     end else begin
                        hit = 0; wd = '0;
                        for (int p = 0; p < NW; p++)
                           if (bus.wb_valid_i[p] && int'(bus.wb_trans_id_i[p]) == q[j].id) begin
                              hit = 1; wd = bus.wb_data_i[p];
                           end
                        if (hit) begin efv = 1; efd = wd; end
                        else eb = 1;
                     end
                  end
            check($sformatf("m_busy%0d", r), bus.rs_busy_o[r], eb);
            check($sformatf("m_fwdv%0d", r), bus.rs_fwd_valid_o[r], efv);
            if (efv) check($sformatf("m_fwdd%0d", r), bus.rs_fwd_data_o[r], efd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush_i       = 1'b0;
      bus.issue_valid_i = 1'b0;
      bus.issue_rd_i    = '0;
      bus.wb_valid_i    = '0;
      bus.wb_trans_id_i = '0;
      bus.wb_data_i     = '0;
      bus.rs_i          = '0;
      bus.commit_ack_i  = '0;
   endtask

   task automatic issue(input logic [4:0] rd);
      bus.issue_valid_i = 1'b1;
      bus.issue_rd_i    = rd;
      tick();
      bus.issue_valid_i = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      bus.rs_i[0] = 5'd5;
      #1;
      check("rst_ready", bus.issue_ready_o, 1);
      check("rst_count", bus.count_o, 0);
      check("rst_cvld",  bus.commit_valid_o, 0);
      check("rst_busy",  bus.rs_busy_o, 0);
      check("rst_fwd",   bus.rs_fwd_valid_o, 0);
      rst_n = 1'b1;
      tick();

      // issue rd 5,6,7
      for (int i = 0; i < 3; i++) begin
         bus.issue_valid_i = 1'b1;
         bus.issue_rd_i    = 5'(5 + i);
         #1;
         check("t1_tid", bus.issue_trans_id_o, i);
         tick();
      end
      idle();
      bus.rs_i[0] = 5'd6;
      #1;
      check("t1_count", bus.count_o, 3);
      check("t1_cvld",  bus.commit_valid_o, 2'b00);
      check("t1_busy",  bus.rs_busy_o[0], 1);

      // out-of-order writeback, then dual commit
      bus.rs_i[0] = 5'd5;
      bus.wb_valid_i = 4'b0011;
      bus.wb_trans_id_i[0] = 3'd1; bus.wb_data_i[0] = 64'h11;
      bus.wb_trans_id_i[1] = 3'd0; bus.wb_data_i[1] = 64'h10;
      #1;
      check("t2_fwdv", bus.rs_fwd_valid_o[0], 1);
      check("t2_fwdd", bus.rs_fwd_data_o[0], 64'h10);
      tick(); idle(); #1;
      check("t2_cvld", bus.commit_valid_o, 2'b11);
      check("t2_crd0", bus.commit_rd_o[0], 5);
      check("t2_crd1", bus.commit_rd_o[1], 6);
      check("t2_cd0",  bus.commit_data_o[0], 64'h10);
      check("t2_cd1",  bus.commit_data_o[1], 64'h11);
      bus.commit_ack_i = 2'b11;
      tick(); idle(); #1;
      check("t2_count", bus.count_o, 1);
      check("t2_tid",   bus.issue_trans_id_o, 3);
      check("t2_cvld0", bus.commit_valid_o, 2'b00);

      // fill to full, commit one with a blocked issue
      for (int i = 0; i < 7; i++) issue(5'(10 + i));
      idle(); #1;
      check("t3_count", bus.count_o, 8);
      check("t3_ready", bus.issue_ready_o, 0);
      check("t3_tid",   bus.issue_trans_id_o, 2);
      bus.wb_valid_i[3] = 1'b1; bus.wb_trans_id_i[3] = 3'd2; bus.wb_data_i[3] = 64'h22;
      tick(); idle(); #1;
      check("t3_cvld", bus.commit_valid_o, 2'b01);
      bus.commit_ack_i = 2'b01;
      bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd20;
      #1;
      check("t3_nofire", bus.issue_ready_o, 0);
      tick(); idle(); #1;
      check("t3_count7", bus.count_o, 7);
      check("t3_ready1", bus.issue_ready_o, 1);
      check("t3_tid2",   bus.issue_trans_id_o, 2);
      bus.flush_i = 1'b1;
      tick(); idle(); #1;
      check("fl_count", bus.count_o, 0);
      check("fl_tid",   bus.issue_trans_id_o, 0);
      check("fl_cvld",  bus.commit_valid_o, 0);

      // two producers of x3
      issue(5'd3);
      issue(5'd3);
      bus.wb_valid_i[0] = 1'b1; bus.wb_trans_id_i[0] = 3'd0; bus.wb_data_i[0] = 64'hA;
      tick(); idle();
      bus.rs_i[0] = 5'd3; bus.rs_i[1] = 5'd0;
      #1;
      check("t4_busy", bus.rs_busy_o[0], 1);
      check("t4_nofwd", bus.rs_fwd_valid_o[0], 0);
      bus.wb_valid_i[2] = 1'b1; bus.wb_trans_id_i[2] = 3'd1; bus.wb_data_i[2] = 64'hB;
      #1;
      check("t4_fwdv",  bus.rs_fwd_valid_o[0], 1);
      check("t4_fwdd",  bus.rs_fwd_data_o[0], 64'hB);
      check("t4_busy0", bus.rs_busy_o[0], 0);
      check("t4_rs0",   {bus.rs_busy_o[1], bus.rs_fwd_valid_o[1]}, 2'b00);
      tick(); idle(); #1;

      // non-prefix ack ignored, then single retire with issue and stray wb
      check("t5_cvld", bus.commit_valid_o, 2'b11);
      bus.commit_ack_i = 2'b10;
      tick(); idle(); #1;
      check("t5_count2", bus.count_o, 2);
      check("t5_cvld11", bus.commit_valid_o, 2'b11);
      bus.commit_ack_i = 2'b01;
      bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd9;
      bus.wb_valid_i[0] = 1'b1; bus.wb_trans_id_i[0] = 3'd2; bus.wb_data_i[0] = 64'h77;
      tick(); idle();
      bus.rs_i[0] = 5'd9; bus.rs_i[1] = 5'd3;
      #1;
      check("t5_count", bus.count_o, 2);
      check("t5_cvld01", bus.commit_valid_o, 2'b01);
      check("t5_crd0", bus.commit_rd_o[0], 3);
      check("t5_cd0",  bus.commit_data_o[0], 64'hB);
      check("t5_busy9", bus.rs_busy_o[0], 1);

      // flush with five in flight and concurrent traffic
      bus.flush_i = 1'b1;
      tick(); idle();
      for (int i = 0; i < 5; i++) issue(5'(1 + i));
      bus.wb_valid_i[0] = 1'b1; bus.wb_trans_id_i[0] = 3'd0; bus.wb_data_i[0] = 64'h100;
      tick(); idle(); #1;
      check("t6_count5", bus.count_o, 5);
      check("t6_cvld01", bus.commit_valid_o, 2'b01);
      bus.flush_i = 1'b1;
      bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd8;
      bus.wb_valid_i[1] = 1'b1; bus.wb_trans_id_i[1] = 3'd1; bus.wb_data_i[1] = 64'h200;
      bus.commit_ack_i = 2'b11;
      tick(); idle();
      bus.rs_i[0] = 5'd1;
      #1;
      check("t6_count", bus.count_o, 0);
      check("t6_tid",   bus.issue_trans_id_o, 0);
      check("t6_cvld",  bus.commit_valid_o, 0);
      check("t6_ready", bus.issue_ready_o, 1);
      check("t6_busy",  bus.rs_busy_o[0], 0);

      // fill from empty: tail wraps to 0
      for (int i = 0; i < 8; i++) issue(5'(10 + i));
      idle(); #1;
      check("t6_full_ready", bus.issue_ready_o, 0);
      check("t6_full_tid",   bus.issue_trans_id_o, 0);
      check("t6_full_count", bus.count_o, 8);

      // reset in the middle of a writeback
      rst_n = 1'b0;
      bus.wb_valid_i[0] = 1'b1; bus.wb_trans_id_i[0] = 3'd3; bus.wb_data_i[0] = 64'h333;
      bus.rs_i[0] = 5'd13;
      tick(); idle();
      bus.rs_i[0] = 5'd13;
      #1;
      check("rst2_count", bus.count_o, 0);
      check("rst2_tid",   bus.issue_trans_id_o, 0);
      check("rst2_ready", bus.issue_ready_o, 1);
      check("rst2_cvld",  bus.commit_valid_o, 0);
      check("rst2_busy",  bus.rs_busy_o, 0);
      check("rst2_fwd",   bus.rs_fwd_valid_o, 0);
      rst_n = 1'b1;
      issue(5'd13);
      idle();
      bus.rs_i[0] = 5'd13;
      #1;
      check("pr_busy", bus.rs_busy_o[0], 1);
      check("pr_cvld", bus.commit_valid_o, 0);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
